// File: rtl/sprite_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_mover_if
// Purpose  : Frame tick, direction levels and position outputs of sprite_mover
// Revision : 1.0
// ============================================================================
interface sprite_mover_if;
    logic       frame_tick;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       step_pulse;

    modport master (
        output frame_tick, move_up, move_down, move_left, move_right,
        input  pos_x, pos_y, step_pulse
    );

    modport slave (
        input  frame_tick, move_up, move_down, move_left, move_right,
        output pos_x, pos_y, step_pulse
    );
endinterface
`default_nettype wire

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// Module   : sprite_mover
// Purpose  : Frame-synchronous object positioning with tap steps and auto-repeat
// Revision : 1.0
// ============================================================================
module sprite_mover #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int OBJ_W        = 16,
    parameter int OBJ_H        = 16,
    parameter int STEP         = 8,
    parameter int X_INIT       = 312,
    parameter int Y_INIT       = 232,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    sprite_mover_if.slave       bus_if
);

    localparam logic [7:0]  DLY_LAST  = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0]  RATE_LAST = 8'(REPEAT_RATE - 1);
    localparam logic [10:0] X_MAX     = 11'(H_RES - OBJ_W);
    localparam logic [10:0] Y_MAX     = 11'(V_RES - OBJ_H);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [9:0]  X_RST     = 10'(X_INIT);
    localparam logic [9:0]  Y_RST     = 10'(Y_INIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  held, held_q, rise;
    logic [3:0]  req_q, req_d, mask;
    logic        fire;
    logic        tick;
    logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic        step_q, step_d;
    logic [10:0] x_sum, y_sum;

    // Bit order {up, down, left, right}
    assign held = {bus_if.move_up, bus_if.move_down, bus_if.move_left, bus_if.move_right};
    assign rise = held & ~held_q;
    assign tick = bus_if.frame_tick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    state_d = DELAY;
                    cnt_d   = 8'd0;
                end
            end
            DELAY: begin
                if (held == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (|rise) begin
                    cnt_d = 8'd0;
                end else if (tick) begin
                    if (cnt_q == DLY_LAST) begin
                        fire    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            REPEAT: begin
                if (held == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (|rise) begin
                    state_d = DELAY;
                    cnt_d   = 8'd0;
                end else if (tick) begin
                    if (cnt_q == RATE_LAST) begin
                        fire  = 1'b1;
                        cnt_d = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        mask    = req_q | rise | (fire ? held : 4'd0);
        req_d   = tick ? 4'd0 : (req_q | rise);
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        x_sum   = {1'b0, pos_x_q} + STEP_W;
        y_sum   = {1'b0, pos_y_q} + STEP_W;
        if (tick) begin
            // Opposing directions on one axis cancel each other
            if (mask[0] && !mask[1]) begin
                pos_x_d = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
            end else if (mask[1] && !mask[0]) begin
                pos_x_d = ({1'b0, pos_x_q} < STEP_W) ? 10'd0 : pos_x_q - STEP_W[9:0];
            end
            if (mask[2] && !mask[3]) begin
                pos_y_d = (y_sum > Y_MAX) ? Y_MAX[9:0] : y_sum[9:0];
            end else if (mask[3] && !mask[2]) begin
                pos_y_d = ({1'b0, pos_y_q} < STEP_W) ? 10'd0 : pos_y_q - STEP_W[9:0];
            end
        end
        step_d = tick && ((pos_x_d != pos_x_q) || (pos_y_d != pos_y_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            held_q  <= 4'd0;
            req_q   <= 4'd0;
            pos_x_q <= X_RST;
            pos_y_q <= Y_RST;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held;
            req_q   <= req_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            step_q  <= step_d;
        end
    end

    assign bus_if.pos_x      = pos_x_q;
    assign bus_if.pos_y      = pos_y_q;
    assign bus_if.step_pulse = step_q;

endmodule
`default_nettype wire
